rot_cipher_pipe_n: RTL and testbench

- Parametrised successor to the single-byte decrypt shift stage.
- Rotates each alphabetic byte of an N-lane beat by a per-beat shift amount, modulo 26.
- Encrypt mode rotates forward; decrypt mode rotates backward. Case is preserved and non-alphabetic bytes pass through unchanged.
- Sits between the byte-stream front end and the output formatter. It is a 2-stage pipeline with full valid/ready backpressure and a synchronous flush.

---
 rtl/rot_cipher_pkg.sv | 41 ++++
 rtl/rot_cipher_pipe_n_lane.sv | 131 +++++++++++++
 rtl/rot_cipher_pipe_n.sv | 83 ++++++++
 tb/tb_rot_cipher_pipe_n.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rot_cipher_pkg.sv
// ============================================================================
//  Module   : rot_cipher_pkg
//  Brief    : Shared types, alphabet constants and mod-reduce helper for the
//             rotating cipher pipeline. Optional macro: ROT_CIPHER_DIGIT_ROT_EN
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rot_cipher_pkg;

    typedef enum logic [1:0] {
        CLS_OTHER = 2'd0,
        CLS_UPPER = 2'd1,
        CLS_LOWER = 2'd2,
        CLS_DIGIT = 2'd3
    } char_class_e;

    localparam logic [5:0] ALPHA_LEN  = 6'd26;
    localparam logic [5:0] DIGIT_LEN  = 6'd10;
    localparam logic [7:0] BASE_UPPER = 8'd65;
    localparam logic [7:0] BASE_LOWER = 8'd97;
    localparam logic [7:0] BASE_DIGIT = 8'd48;

    // Restoring-remainder reduction: one compare/subtract per input bit, so an
    // arbitrary-width shift is reduced without a divider.
    function automatic logic [5:0] mod_reduce(input logic [31:0] val,
                                              input logic [5:0]  modulus);
        logic [6:0] rem;
        rem = '0;
        for (int i = 31; i >= 0; i--) begin
            rem = {rem[5:0], val[i]};
            if (rem >= {1'b0, modulus}) begin
                rem = rem - {1'b0, modulus};
            end
        end
        return rem[5:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/rot_cipher_pipe_n_lane.sv
// ============================================================================
//  Module   : rot_cipher_lane
//  Brief    : Two-stage rotate datapath for a single byte (no handshake).
//             Optional macro: ROT_CIPHER_DIGIT_ROT_EN (digits rotate mod 10)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rot_cipher_lane
    import rot_cipher_pkg::*;
#(
    parameter int SHIFT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en1,
    input  logic               en2,
    input  logic [7:0]         in_byte,
    input  logic [SHIFT_W-1:0] in_shift,
    input  logic               in_mode,
    input  logic               in_bypass,
    output logic [7:0]         out_byte
);

    char_class_e w_class;
    logic [4:0]  w_index;
    logic [4:0]  w_shift_a;

    char_class_e r_class;
    logic [4:0]  r_index;
    logic [4:0]  r_shift_a;
    logic        r_mode;
    logic        r_bypass;
    logic [7:0]  r_raw;

    logic [5:0]  w_sum_a;
    logic [5:0]  w_idx_a;
    logic [7:0]  w_out;
    logic [7:0]  r_out;

    assign w_shift_a = 5'(mod_reduce(32'(in_shift), ALPHA_LEN));

    always_comb begin
        w_class = CLS_OTHER;
        w_index = '0;
        if (in_byte >= BASE_UPPER && in_byte <= BASE_UPPER + 8'd25) begin
            w_class = CLS_UPPER;
            w_index = 5'(in_byte - BASE_UPPER);
        end else if (in_byte >= BASE_LOWER && in_byte <= BASE_LOWER + 8'd25) begin
            w_class = CLS_LOWER;
            w_index = 5'(in_byte - BASE_LOWER);
        end
`ifdef ROT_CIPHER_DIGIT_ROT_EN
        else if (in_byte >= BASE_DIGIT && in_byte <= BASE_DIGIT + 8'd9) begin
            w_class = CLS_DIGIT;
            w_index = 5'(in_byte - BASE_DIGIT);
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_class   <= CLS_OTHER;
            r_index   <= '0;
            r_shift_a <= '0;
            r_mode    <= 1'b0;
            r_bypass  <= 1'b0;
            r_raw     <= '0;
        end else if (en1) begin
            r_class   <= w_class;
            r_index   <= w_index;
            r_shift_a <= w_shift_a;
            r_mode    <= in_mode;
            r_bypass  <= in_bypass;
            r_raw     <= in_byte;
        end
    end

    // Decrypt adds the complement so the sum never goes negative.
    assign w_sum_a = r_mode ? ({1'b0, r_index} + ALPHA_LEN - {1'b0, r_shift_a})
                            : ({1'b0, r_index} + {1'b0, r_shift_a});
    assign w_idx_a = (w_sum_a >= ALPHA_LEN) ? (w_sum_a - ALPHA_LEN) : w_sum_a;

`ifdef ROT_CIPHER_DIGIT_ROT_EN
    logic [3:0] w_shift_d;
    logic [3:0] r_shift_d;
    logic [5:0] w_sum_d;
    logic [5:0] w_idx_d;

    assign w_shift_d = 4'(mod_reduce(32'(in_shift), DIGIT_LEN));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift_d <= '0;
        end else if (en1) begin
            r_shift_d <= w_shift_d;
        end
    end

    assign w_sum_d = r_mode ? ({1'b0, r_index} + DIGIT_LEN - {2'b00, r_shift_d})
                            : ({1'b0, r_index} + {2'b00, r_shift_d});
    assign w_idx_d = (w_sum_d >= DIGIT_LEN) ? (w_sum_d - DIGIT_LEN) : w_sum_d;
`endif

    always_comb begin
        w_out = r_raw;
        if (!r_bypass) begin
            case (r_class)
                CLS_UPPER: w_out = BASE_UPPER + {2'b00, w_idx_a};
                CLS_LOWER: w_out = BASE_LOWER + {2'b00, w_idx_a};
`ifdef ROT_CIPHER_DIGIT_ROT_EN
                CLS_DIGIT: w_out = BASE_DIGIT + {2'b00, w_idx_d};
`endif
                default:   w_out = r_raw;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out <= '0;
        end else if (en2) begin
            r_out <= w_out;
        end
    end

    assign out_byte = r_out;

endmodule

`default_nettype wire

// File: rtl/rot_cipher_pipe_n.sv
// ============================================================================
//  Module   : rot_cipher_pipe_n
//  Brief    : N-lane, 2-stage rotating cipher with valid/ready and flush.
//             Optional macro: ROT_CIPHER_DIGIT_ROT_EN (digits rotate mod 10)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rot_cipher_pipe_n
    import rot_cipher_pkg::*;
#(
    parameter int N_LANES = 4,
    parameter int SHIFT_W = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [8*N_LANES-1:0]   in_data,
    input  logic [SHIFT_W-1:0]     in_shift,
    input  logic                   in_mode,
    input  logic                   in_bypass,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*N_LANES-1:0]   out_data
);

    logic r_s1_valid;
    logic r_s2_valid;
    logic w_adv1;
    logic w_adv2;
    logic w_en1;
    logic w_en2;

    assign w_adv2   = !r_s2_valid || out_ready;
    assign w_adv1   = !r_s1_valid || w_adv2;
    assign in_ready = w_adv1;

    // Data registers only need to load when a real beat moves in.
    assign w_en1 = w_adv1 && in_valid;
    assign w_en2 = w_adv2 && r_s1_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            if (w_adv1) begin
                r_s1_valid <= in_valid;
            end
            if (w_adv2) begin
                r_s2_valid <= r_s1_valid;
            end
        end
    end

    assign out_valid = r_s2_valid;

    generate
        for (genvar k = 0; k < N_LANES; k++) begin : g_lane
            rot_cipher_lane #(
                .SHIFT_W (SHIFT_W)
            ) u_lane (
                .clk       (clk),
                .rst       (rst),
                .en1       (w_en1),
                .en2       (w_en2),
                .in_byte   (in_data[8*k +: 8]),
                .in_shift  (in_shift),
                .in_mode   (in_mode),
                .in_bypass (in_bypass),
                .out_byte  (out_data[8*k +: 8])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_rot_cipher_pipe_n.sv
// ============================================================================
//  Module   : tb_rot_cipher_pipe_n
//  Brief    : Self-checking bench for rot_cipher_pipe_n against a behavioural
//             mod-26 / mod-10 model. Honours ROT_CIPHER_DIGIT_ROT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rot_cipher_pipe_n;

    localparam int N_LANES = 4;
    localparam int SHIFT_W = 5;
    localparam int DW      = 8 * N_LANES;

    logic            clk;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic [SHIFT_W-1:0] in_shift;
    logic            in_mode;
    logic            in_bypass;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;

    int total;
    int bad;
    logic [DW-1:0] exp_q[$];

    rot_cipher_pipe_n #(
        .N_LANES (N_LANES),
        .SHIFT_W (SHIFT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shift  (in_shift),
        .in_mode   (in_mode),
        .in_bypass (in_bypass),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ref_byte(input logic [7:0] b, input int sh,
                                            input logic mode, input logic byp);
        int v;
        v = int'(b);
        if (byp) return b;
        if (v >= 65 && v <= 90)
            return 8'(65 + (mode ? (v - 65 - sh % 26 + 26) % 26 : (v - 65 + sh) % 26));
        if (v >= 97 && v <= 122)
            return 8'(97 + (mode ? (v - 97 - sh % 26 + 26) % 26 : (v - 97 + sh) % 26));
`ifdef ROT_CIPHER_DIGIT_ROT_EN
        if (v >= 48 && v <= 57)
            return 8'(48 + (mode ? (v - 48 - sh % 10 + 10) % 10 : (v - 48 + sh) % 10));
`endif
        return b;
    endfunction

    function automatic logic [DW-1:0] ref_beat(input logic [DW-1:0] d, input int sh,
                                               input logic mode, input logic byp);
        logic [DW-1:0] r;
        for (int k = 0; k < N_LANES; k++) r[8*k +: 8] = ref_byte(d[8*k +: 8], sh, mode, byp);
        return r;
    endfunction

    // Lane 0 carries the first character of the string.
    function automatic logic [DW-1:0] str4(input string s);
        logic [DW-1:0] r;
        for (int k = 0; k < N_LANES; k++) r[8*k +: 8] = s[k];
        return r;
    endfunction

    function automatic logic [7:0] rand_char();
        case ($urandom_range(0, 3))
            0:       return 8'($urandom_range(65, 90));
            1:       return 8'($urandom_range(97, 122));
            2:       return 8'($urandom_range(48, 57));
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        in_shift = '0; in_mode = 1'b0; in_bypass = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++;
        if (out_data !== '0) begin bad++; $display("FAIL reset_out_data got=%h want=0", out_data); end
        rst = 1'b1;
        @(negedge clk); #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_latency_vector(input string name, input logic [DW-1:0] din, input int sh,
                                       input logic mode, input logic byp, input logic [DW-1:0] exp);
        @(negedge clk);
        flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; in_data = din; in_shift = SHIFT_W'(sh); in_mode = mode; in_bypass = byp;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL %s_in_ready got=%b want=1", name, in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL %s_early_valid got=%b want=0", name, out_valid); end
        @(negedge clk); #1;
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL %s_valid_at_2 got=%b want=1", name, out_valid); end
        total++;
        if (out_data !== exp) begin bad++; $display("FAIL %s_data got=%h want=%h", name, out_data, exp); end
    endtask

    task automatic test_vectors();
        test_latency_vector("decrypt3", str4("DdAa"), 3, 1'b1, 1'b0, str4("AaXx"));
`ifdef ROT_CIPHER_DIGIT_ROT_EN
        test_latency_vector("encrypt1", str4("Zz!9"), 1, 1'b0, 1'b0, str4("Aa!0"));
`else
        test_latency_vector("encrypt1", str4("Zz!9"), 1, 1'b0, 1'b0, str4("Aa!9"));
`endif
        test_latency_vector("shift29", str4("abc "), 29, 1'b0, 1'b0, str4("def "));
        test_latency_vector("bypass", str4("Hi!z"), 7, 1'b1, 1'b1, str4("Hi!z"));
        test_latency_vector("dec_wrap", str4("aZ0m"), 31, 1'b1, 1'b0,
                            ref_beat(str4("aZ0m"), 31, 1'b1, 1'b0));
    endtask

    task automatic test_random();
        logic          stalled;
        logic [DW-1:0] held;
        logic [DW-1:0] d;
        int            sh;
        int            got;
        stalled = 1'b0; held = '0; got = 0;
        exp_q.delete();
        for (int c = 0; c < 420; c++) begin
            @(negedge clk);
            if (c < 400) begin
                for (int k = 0; k < N_LANES; k++) d[8*k +: 8] = rand_char();
                sh = int'($urandom_range(0, 31));
                in_valid  = ($urandom_range(0, 3) != 0);
                in_data   = d;
                in_shift  = SHIFT_W'(sh);
                in_mode   = 1'($urandom_range(0, 1));
                in_bypass = ($urandom_range(0, 7) == 0);
                out_ready = ($urandom_range(0, 2) != 0);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            #1;
            if (stalled) begin
                total++;
                if (out_valid !== 1'b1 || out_data !== held) begin
                    bad++; $display("FAIL rand_hold got=%b/%h want=1/%h", out_valid, out_data, held);
                end
            end
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL rand_extra_beat got=%h want=none", out_data);
                end else begin
                    got++;
                    if (out_data !== exp_q[0]) begin
                        bad++; $display("FAIL rand_data got=%h want=%h", out_data, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
            end
            stalled = out_valid && !out_ready;
            held    = out_data;
            if (in_valid && in_ready) exp_q.push_back(ref_beat(in_data, int'(in_shift), in_mode, in_bypass));
        end
        total++;
        if (exp_q.size() != 0 || got < 50) begin
            bad++; $display("FAIL rand_drain left=%0d got=%0d want=0/>=50", exp_q.size(), got);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] beats[4];
        logic [DW-1:0] first;
        int            acc;
        int            got;
        beats[0] = str4("Abcd"); beats[1] = str4("wxyz");
        beats[2] = str4("M-N5"); beats[3] = str4("qrsT");
        acc = 0; got = 0;
        exp_q.delete();
        first = ref_beat(beats[0], 5, 1'b0, 1'b0);
        for (int c = 0; c < 40 && got < 4; c++) begin
            @(negedge clk);
            out_ready = (c >= 7);
            in_valid  = (acc < 4);
            in_data   = beats[acc % 4];
            in_shift  = SHIFT_W'(5); in_mode = 1'b0; in_bypass = 1'b0;
            #1;
            if (c == 6) begin
                total++;
                if (acc !== 2 || in_ready !== 1'b0) begin
                    bad++; $display("FAIL b2b_fill got=acc%0d/rdy%b want=acc2/rdy0", acc, in_ready);
                end
            end
            if (c >= 2 && c < 7) begin
                total++;
                if (out_valid !== 1'b1 || out_data !== first) begin
                    bad++; $display("FAIL b2b_stall_hold got=%b/%h want=1/%h", out_valid, out_data, first);
                end
            end
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0 || out_data !== exp_q[0]) begin
                    bad++; $display("FAIL b2b_order got=%h want=%h", out_data,
                                    exp_q.size() ? exp_q[0] : '0);
                end
                if (exp_q.size()) void'(exp_q.pop_front());
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_beat(in_data, 5, 1'b0, 1'b0));
                acc++;
            end
        end
        in_valid = 1'b0;
        total++;
        if (got !== 4) begin bad++; $display("FAIL b2b_count got=%0d want=4", got); end
    endtask

    task automatic test_flush();
        @(negedge clk);
        out_ready = 1'b1; in_shift = SHIFT_W'(2); in_mode = 1'b0; in_bypass = 1'b0;
        in_valid = 1'b1; in_data = str4("aaaa");
        @(negedge clk);
        in_data = str4("bbbb");
        @(negedge clk);
        out_ready = 1'b0; flush = 1'b1; in_data = str4("cccc");
        #1;
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL flush_pre_full got=%b want=1", out_valid); end
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            total++;
            if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_no_output c=%0d got=%b want=0", c, out_valid); end
            @(negedge clk);
        end
        test_latency_vector("post_flush", str4("Flu5"), 4, 1'b0, 1'b0,
                            ref_beat(str4("Flu5"), 4, 1'b0, 1'b0));
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        out_ready = 1'b0; in_shift = SHIFT_W'(9); in_mode = 1'b1; in_bypass = 1'b0;
        in_valid = 1'b1; in_data = str4("Reset");
        @(negedge clk);
        in_data = str4("mid!");
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL areset_pre_full got=%b want=1", out_valid); end
        #1;
        rst = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || out_data !== '0) begin
            bad++; $display("FAIL areset_immediate got=%b/%h want=0/0", out_valid, out_data);
        end
        @(negedge clk);
        rst = 1'b1; out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL areset_in_ready got=%b want=1", in_ready); end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            total++;
            if (out_valid !== 1'b0) begin bad++; $display("FAIL areset_stale c=%0d got=%b want=0", c, out_valid); end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_vectors();
        test_back_to_back();
        test_flush();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
